xy_output_port_arbiter: RTL and testbench
=========================================

# xy_output_port_arbiter

- Clocked round-robin arbiter for one output port of the 5-port X-Y mesh router (N, S, E, W, PE).
- Shares that port among the five input-side routing processes.
- Each requester offers one 32-bit single-flit packet (fields as in the router: [31:30] src X, [29:28] src Y, [27:26] dst X, [25:24] dst Y); the block grants one requester per cycle and registers the packet into a one-entry output stage.
- The router instantiates one copy per output port; the block never inspects or rewrites address fields.

## Interface

Parameters:
- WIDTH, 32, packet width in bits.
- NUM_REQ, 5, requester count; index 0=N, 1=S, 2=E, 3=W, 4=PE.
- CNT_W, 16, width of delivered-packet counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester packet-offered flag.
- req_data  in  NUM_REQ*WIDTH  packets; requester i at [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot-or-zero grant; requester i's packet is consumed when req_valid[i] && req_ready[i] at a clock edge.
- out_valid  out  1  output stage holds a packet.
- out_data  out  WIDTH  held packet.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- grant_idx  out  3  index of the most recently granted requester (registered).
- pkt_count  out  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation

- **State:** EMPTY (out_valid=0) or FULL (out_valid=1), plus round-robin pointer ptr (0..NUM_REQ-1).
- **Accept condition:** can_accept = !out_valid || out_ready.
- **Grant selection:**
  - Combinational: g = first i with req_valid[i], searching ptr, ptr+1, …, wrapping past NUM_REQ-1 to 0.
  - req_ready[g]=1 only when can_accept && !rst; otherwise req_ready = 0.
  - req_ready never depends on req_data.
- **On grant edge:**
  - out_data <= packet g; out_valid <= 1; grant_idx <= g.
  - ptr <= (g==NUM_REQ-1) ? 0 : g+1.
- **Drain without refill:** on an out_valid && out_ready edge with no grant, out_valid <= 0; out_data retains its last value.
- **Simultaneous drain and grant:** both happen on the same edge. State stays FULL and the new packet replaces the old, giving full throughput of one packet per cycle.
- **Output counter:** pkt_count increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- **No valid requests:** no grant; ptr unchanged.
- **Transitions:**
  - EMPTY→FULL on grant.
  - FULL→EMPTY on drain without grant.
  - FULL→FULL on grant with drain, or on stall (out_ready=0).
- **Stall:** while FULL && !out_ready, out_data and grant_idx are stable and every req_ready = 0.
- **Fairness:** a continuously valid requester is granted within NUM_REQ grants.

## Timing

- **Reset values:** out_valid=0, out_data=0, grant_idx=0, pkt_count=0, ptr=0; req_ready=0 during the rst cycle.
- **Reset mid-operation:** a held packet is discarded and the cycle's offered packet is not consumed.
- **Latency:** request accepted at edge k → out_valid=1 with that packet after edge k; earliest downstream transfer at edge k+1.
- **Throughput:** 1 packet/cycle with out_ready tied high.
- **Combinational paths:** req_valid→req_ready and out_ready→req_ready (drain-and-refill). No combinational path from any input to out_valid, out_data, grant_idx or pkt_count.
- **Requester rule:** a requester keeps req_valid and req_data stable until granted.

## Test plan

- **Single requester, no backpressure:** after reset, req_valid=5'b00100 (E) with data 0x1234_5678, out_ready=1.
  - req_ready=5'b00100 in the first cycle.
  - Next cycle out_valid=1, out_data=0x1234_5678, grant_idx=2.
  - pkt_count=1 after the transfer edge.
- **All five requesters valid continuously, out_ready=1:** grant order 0,1,2,3,4,0…, one per cycle; 10 transfers give pkt_count=10.
- **Backpressure:** requester 1 granted, then out_ready=0 for 4 cycles.
  - out_data held and req_ready=0 throughout.
  - When out_ready rises, requester 3 (pending) is granted in that same cycle; out_data becomes its packet one edge later.
- **Wrap and fairness:** ptr at 4 with req_valid=5'b10001: grant 4, then 0, then 4.
  - Dropping req_valid[4] while the 0 grant is pending yields 0 only.
- **Counter wrap:** CNT_W=4, 17 transfers → pkt_count=1.
- **Reset mid-operation:** rst asserted while FULL with out_ready=0.
  - After the rst edge: out_valid=0, pkt_count=0, ptr=0, req_ready=0.
  - First grant after rst deasserts goes to the lowest valid index.

Source files
------------

// File: rtl/xy_output_port_arbiter.sv
// xy_output_port_arbiter: round-robin arbiter sharing one mesh-router output port among five requesters
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_ready per-requester handshake;
//        out_valid/out_data/out_ready one-entry output stage; grant_idx last granted requester;
//        pkt_count completed output transfers (wrapping).
module xy_output_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 5,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [2:0]               grant_idx,
  output logic [CNT_W-1:0]         pkt_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, g;
  logic hit, grant, drain;
  int j;
  // Search from the farthest offset back to ptr so the nearest valid requester wins.
  always_comb begin
    g = ptr;
    hit = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[j]) begin
        g = 3'(j);
        hit = 1'b1;
      end
    end
  end
  assign drain = out_valid && out_ready;
  assign grant = hit && (!out_valid || out_ready) && !rst;
  assign req_ready = grant ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nx;
  always_comb state_nx = grant ? FULL : drain ? EMPTY : state;
  always_comb out_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      grant_idx <= '0;
      pkt_count <= '0;
      ptr       <= '0;
    end else begin
      pkt_count <= pkt_count + CNT_W'(drain);
      if (grant) begin
        out_data  <= req_data[g*WIDTH +: WIDTH];
        grant_idx <= g;
        ptr       <= (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_xy_output_port_arbiter.sv
// tb_xy_output_port_arbiter: directed scoreboard bench for xy_output_port_arbiter
module tb_xy_output_port_arbiter;
  localparam int W = 32;
  localparam int N = 5;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [2:0] grant_idx;
  logic [C-1:0] pkt_count;
  int passes = 0;
  int total = 0;
  logic m_valid;
  int m_ptr;
  logic [C-1:0] m_cnt;
  logic [W+2:0] q[$];
  logic [W-1:0] p1, p3;

  xy_output_port_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: predict grant from the bench model, check, advance the model.
  task automatic tick();
    int eg;
    logic can;
    logic [N-1:0] er;
    logic [W+2:0] e;
    #1;
    eg = -1;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
    can = !m_valid || out_ready;
    er = (eg >= 0 && can && !rst) ? N'(1) << eg : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
    if (m_valid && out_ready && !rst) begin
      chk("sb_size", 64'(q.size()), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(e[W-1:0]));
        chk("out_idx", 64'(grant_idx), 64'(e[W+2:W]));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr = 0;
      m_cnt = '0;
      q.delete();
    end else begin
      if (m_valid && out_ready) m_cnt++;
      if (er != 0) begin
        q.push_back({3'(eg), req_data[eg*W +: W]});
        m_ptr = (eg == N - 1) ? 0 : eg + 1;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
    @(negedge clk);
    if (er != 0) req_data[eg*W +: W] = $urandom();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom();
    m_valid = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    // single requester E
    rst = 1'b0;
    req_data[2*W +: W] = 32'h1234_5678;
    req_valid = 5'b00100;
    out_ready = 1'b1;
    #1 chk("e_ready", 64'(req_ready), 64'b00100);
    tick();
    req_valid = '0;
    chk("e_out_valid", 64'(out_valid), 64'd1);
    chk("e_out_data", 64'(out_data), 64'h1234_5678);
    chk("e_grant_idx", 64'(grant_idx), 64'd2);
    tick();
    chk("e_pkt_count", 64'(pkt_count), 64'd1);
    // all five continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_order", 64'(grant_idx), 64'(i % 5));
    end
    req_valid = '0;
    tick();
    chk("rr_pkt_count", 64'(pkt_count), 64'd10);
    // backpressure
    req_valid = 5'b00010;
    p1 = req_data[1*W +: W];
    tick();
    out_ready = 1'b0;
    req_valid = 5'b01000;
    p3 = req_data[3*W +: W];
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_data", 64'(out_data), 64'(p1));
      chk("bp_hold_idx", 64'(grant_idx), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_regrant", 64'(req_ready), 64'b01000);
    tick();
    req_valid = '0;
    chk("bp_new_data", 64'(out_data), 64'(p3));
    chk("bp_new_idx", 64'(grant_idx), 64'd3);
    tick();
    // wrap and fairness from ptr 4
    req_valid = 5'b10001;
    tick();
    chk("wrap_g4a", 64'(grant_idx), 64'd4);
    tick();
    chk("wrap_g0", 64'(grant_idx), 64'd0);
    tick();
    chk("wrap_g4b", 64'(grant_idx), 64'd4);
    req_valid = 5'b00001;
    tick();
    chk("wrap_only0", 64'(grant_idx), 64'd0);
    req_valid = '0;
    tick();
    tick();
    // counter wrap with 4-bit counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 5'b00001;
    for (int i = 0; i < 17; i++) tick();
    req_valid = '0;
    tick();
    chk("cnt_wrap", 64'(pkt_count), 64'd1);
    // reset mid-operation while stalled
    req_valid = 5'b00100;
    tick();
    out_ready = 1'b0;
    req_valid = 5'b01000;
    tick();
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_pkt_count", 64'(pkt_count), 64'd0);
    chk("mid_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    req_valid = 5'b11010;
    out_ready = 1'b1;
    tick();
    chk("mid_first_grant", 64'(grant_idx), 64'd1);
    req_valid = '0;
    tick();
    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
